// File: rtl/retire_status_unit.sv
// Retire/commit status tracker for a two-thread, two-ROB pipeline: thread and pipeline FSMs plus retire counters.
// Define RETIRE_BRANCH_CNT_EN to build the branch / correct-branch counters; otherwise both outputs read 0.
module retire_status_unit #(
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           rob0_commit,
    input  logic [1:0]           rob1_commit,
    input  logic [1:0]           rob0_halt_slot,
    input  logic [1:0]           rob1_halt_slot,
    input  logic [1:0]           rob0_illegal_slot,
    input  logic [1:0]           rob1_illegal_slot,
    input  logic [1:0]           rob0_br_slot,
    input  logic [1:0]           rob0_br_ok_slot,
    input  logic [1:0]           rob1_br_slot,
    input  logic [1:0]           rob1_br_ok_slot,
    input  logic                 thread1_fork,
    input  logic                 mem_error,
    output logic [3:0]           pipeline_status,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] correct_branch_count,
    output logic                 thread0_done,
    output logic                 thread1_done,
    output logic                 thread1_active,
    output logic                 stop_fetch
);

    typedef enum logic [1:0] {T_IDLE, T_ACTIVE, T_HALTED} thread_e;
    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_STOPPED} pipe_e;
    typedef enum logic [3:0] {
        ST_NO_ERROR  = 4'd0,
        ST_MEM_ERROR = 4'd1,
        ST_HALT      = 4'd2,
        ST_ILLEGAL   = 4'd3
    } status_e;

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    pipe_e         state, state_next;
    thread_e       t0, t1, t0_next, t1_next;
    logic [DW-1:0] drain_cnt, drain_next;
    logic [3:0]    status_next;

    logic       active0, active1;
    logic [1:0] v0, v1, cnt0, cnt1;
    logic       halt0, halt1, illegal_hit, stopping;
    logic [2:0] instr_inc;

    function automatic logic [2:0] pop4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    always_comb begin
        active0 = (t0 == T_ACTIVE) && (state != S_STOPPED);
        active1 = (t1 == T_ACTIVE) && (state != S_STOPPED);

        // A valid halt or illegal in slot 0 squashes the younger slot 1 of the same thread.
        v0    = rob0_commit & {2{active0}};
        v0[1] = v0[1] & ~(v0[0] & (rob0_halt_slot[0] | rob0_illegal_slot[0]));
        v1    = rob1_commit & {2{active1}};
        v1[1] = v1[1] & ~(v1[0] & (rob1_halt_slot[0] | rob1_illegal_slot[0]));

        cnt0 = v0 & ~rob0_halt_slot & ~rob0_illegal_slot;
        cnt1 = v1 & ~rob1_halt_slot & ~rob1_illegal_slot;
        instr_inc = pop4({cnt1, cnt0});

        halt0       = |(v0 & rob0_halt_slot);
        halt1       = |(v1 & rob1_halt_slot);
        illegal_hit = (state == S_RUN) && |((v0 & rob0_illegal_slot) | (v1 & rob1_illegal_slot));
        stopping    = (mem_error && (state != S_STOPPED)) || illegal_hit;

        t0_next = t0;
        t1_next = t1;
        if (halt0 && !stopping) t0_next = T_HALTED;
        if (halt1 && !stopping) t1_next = T_HALTED;
        else if ((state == S_RUN) && thread1_fork && (t1 == T_IDLE) && !stopping) t1_next = T_ACTIVE;

        state_next  = state;
        drain_next  = drain_cnt;
        status_next = pipeline_status;
        case (state)
            S_RUN: begin
                if (mem_error) begin
                    state_next  = S_STOPPED;
                    status_next = ST_MEM_ERROR;
                end else if (illegal_hit) begin
                    state_next  = S_STOPPED;
                    status_next = ST_ILLEGAL;
                end else if ((t0_next == T_HALTED) && (t1_next != T_ACTIVE)) begin
                    state_next = S_DRAIN;
                    drain_next = '0;
                end
            end
            S_DRAIN: begin
                if (mem_error) begin
                    state_next  = S_STOPPED;
                    status_next = ST_MEM_ERROR;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_next  = S_STOPPED;
                    status_next = ST_HALT;
                end else begin
                    drain_next = drain_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= S_RUN;
            t0              <= T_ACTIVE;
            t1              <= T_IDLE;
            drain_cnt       <= '0;
            pipeline_status <= ST_NO_ERROR;
            instr_count     <= '0;
            cycle_count     <= '0;
            thread0_done    <= 1'b0;
            thread1_done    <= 1'b0;
            thread1_active  <= 1'b0;
            stop_fetch      <= 1'b0;
        end else begin
            state           <= state_next;
            t0              <= t0_next;
            t1              <= t1_next;
            drain_cnt       <= drain_next;
            pipeline_status <= status_next;
            thread0_done    <= (t0_next == T_HALTED);
            thread1_done    <= (t1_next == T_HALTED);
            thread1_active  <= (t1_next == T_ACTIVE);
            stop_fetch      <= (state_next != S_RUN);
            if (state != S_STOPPED) begin
                instr_count <= instr_count + CNT_WIDTH'(instr_inc);
                cycle_count <= cycle_count + 1'b1;
            end
        end
    end

`ifdef RETIRE_BRANCH_CNT_EN
    logic [1:0] br0, br1, ok0, ok1;

    always_comb begin
        br0 = cnt0 & rob0_br_slot;
        br1 = cnt1 & rob1_br_slot;
        ok0 = br0 & rob0_br_ok_slot;
        ok1 = br1 & rob1_br_ok_slot;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            branch_count         <= '0;
            correct_branch_count <= '0;
        end else if (state != S_STOPPED) begin
            branch_count         <= branch_count + CNT_WIDTH'(pop4({br1, br0}));
            correct_branch_count <= correct_branch_count + CNT_WIDTH'(pop4({ok1, ok0}));
        end
    end
`else
    logic unused_branch_inputs;

    assign unused_branch_inputs = ^{rob0_br_slot, rob0_br_ok_slot, rob1_br_slot, rob1_br_ok_slot};
    assign branch_count         = '0;
    assign correct_branch_count = '0;
`endif

endmodule

// File: tb/tb_retire_status_unit.sv
// Directed self-checking bench for retire_status_unit (default parameters).
module tb_retire_status_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  rob0_commit, rob1_commit, rob0_halt_slot, rob1_halt_slot;
    logic [1:0]  rob0_illegal_slot, rob1_illegal_slot;
    logic [1:0]  rob0_br_slot, rob0_br_ok_slot, rob1_br_slot, rob1_br_ok_slot;
    logic        thread1_fork, mem_error;
    logic [3:0]  pipeline_status;
    logic [31:0] instr_count, cycle_count, branch_count, correct_branch_count;
    logic        thread0_done, thread1_done, thread1_active, stop_fetch;

    int checks = 0;
    int errors = 0;

    retire_status_unit #(.CNT_WIDTH(32), .DRAIN_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .rob0_commit(rob0_commit), .rob1_commit(rob1_commit),
        .rob0_halt_slot(rob0_halt_slot), .rob1_halt_slot(rob1_halt_slot),
        .rob0_illegal_slot(rob0_illegal_slot), .rob1_illegal_slot(rob1_illegal_slot),
        .rob0_br_slot(rob0_br_slot), .rob0_br_ok_slot(rob0_br_ok_slot),
        .rob1_br_slot(rob1_br_slot), .rob1_br_ok_slot(rob1_br_ok_slot),
        .thread1_fork(thread1_fork), .mem_error(mem_error),
        .pipeline_status(pipeline_status),
        .instr_count(instr_count), .cycle_count(cycle_count),
        .branch_count(branch_count), .correct_branch_count(correct_branch_count),
        .thread0_done(thread0_done), .thread1_done(thread1_done),
        .thread1_active(thread1_active), .stop_fetch(stop_fetch)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rob0_commit = '0; rob1_commit = '0; rob0_halt_slot = '0; rob1_halt_slot = '0;
        rob0_illegal_slot = '0; rob1_illegal_slot = '0;
        rob0_br_slot = '0; rob0_br_ok_slot = '0; rob1_br_slot = '0; rob1_br_ok_slot = '0;
        thread1_fork = 1'b0; mem_error = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #2;
        check("async_reset_status", pipeline_status, 0);
        check("async_reset_instr", instr_count, 0);
        check("async_reset_stop_fetch", stop_fetch, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        check("reset_cycle", cycle_count, 0);
        check("reset_t1_active", thread1_active, 0);
        check("reset_t0_done", thread0_done, 0);

        // Thread 0 commits 2/cycle for 5 cycles, then halts in slot 0 with slot 1 valid
        rob0_commit = 2'b11;
        step();
        check("a_instr_first", instr_count, 2);
        check("a_cycle_first", cycle_count, 1);
        repeat (4) step();
        check("a_instr_5", instr_count, 10);
        rob0_halt_slot = 2'b01;
        step();
        clear_inputs();
        check("a_instr_halt", instr_count, 10);
        check("a_t0_done", thread0_done, 1);
        check("a_stop_fetch", stop_fetch, 1);
        check("a_status_drain", pipeline_status, 0);
        repeat (3) step();
        check("a_status_drain3", pipeline_status, 0);
        step();
        check("a_status_halt", pipeline_status, 2);
        check("a_cycle_stop", cycle_count, 10);
        rob0_commit = 2'b11;
        repeat (2) step();
        check("a_instr_frozen", instr_count, 10);
        check("a_cycle_frozen", cycle_count, 10);

        // Asynchronous reset in STOPPED, checked before any clock edge
        reset = 1'b1;
        #2;
        check("r_status", pipeline_status, 0);
        check("r_instr", instr_count, 0);
        check("r_cycle", cycle_count, 0);
        check("r_stop_fetch", stop_fetch, 0);
        check("r_t1_active", thread1_active, 0);
        apply_reset();

        // Thread 1 commits before fork are ignored; fork, thread 0 halts, thread 1 halts 3 cycles later
        rob1_commit = 2'b11;
        step();
        check("b_t1_idle_commit", instr_count, 0);
        clear_inputs();
        thread1_fork = 1'b1;
        step();
        clear_inputs();
        check("b_t1_active", thread1_active, 1);
        rob0_commit = 2'b01; rob0_halt_slot = 2'b01;
        step();
        clear_inputs();
        check("b_t0_done", thread0_done, 1);
        check("b_no_drain_yet", stop_fetch, 0);
        repeat (2) step();
        check("b_no_drain_later", stop_fetch, 0);
        rob1_commit = 2'b01; rob1_halt_slot = 2'b01;
        step();
        clear_inputs();
        check("b_t1_done", thread1_done, 1);
        check("b_t1_inactive", thread1_active, 0);
        check("b_drain", stop_fetch, 1);
        repeat (3) step();
        check("b_status_drain3", pipeline_status, 0);
        step();
        check("b_status_halt", pipeline_status, 2);
        check("b_instr", instr_count, 0);

        // Illegal in rob1 slot 0 with halt in rob0 slot 1; rob0 slot 0 is an ordinary commit
        apply_reset();
        thread1_fork = 1'b1;
        step();
        clear_inputs();
        rob0_commit = 2'b11; rob0_halt_slot = 2'b10;
        rob1_commit = 2'b01; rob1_illegal_slot = 2'b01;
        step();
        clear_inputs();
        check("c_status_illegal", pipeline_status, 3);
        check("c_instr", instr_count, 1);
        check("c_stop_fetch", stop_fetch, 1);

        // Same thread: older illegal masks younger halt
        apply_reset();
        rob0_commit = 2'b11; rob0_illegal_slot = 2'b01; rob0_halt_slot = 2'b10;
        step();
        clear_inputs();
        check("d_status_illegal", pipeline_status, 3);
        check("d_instr", instr_count, 0);

        // mem_error during the second DRAIN cycle
        apply_reset();
        rob0_commit = 2'b01; rob0_halt_slot = 2'b01;
        step();
        clear_inputs();
        step();
        mem_error = 1'b1;
        step();
        clear_inputs();
        check("e_status_mem", pipeline_status, 1);
        check("e_cycle", cycle_count, 3);
        rob0_commit = 2'b11;
        repeat (2) step();
        check("e_cycle_frozen", cycle_count, 3);
        check("e_status_hold", pipeline_status, 1);

        // mem_error outranks illegal in the same cycle
        apply_reset();
        rob0_commit = 2'b01; rob0_illegal_slot = 2'b01; mem_error = 1'b1;
        step();
        clear_inputs();
        check("f_status_priority", pipeline_status, 1);

        // Both ROBs retire two branches per cycle, one of four mispredicted, for 3 cycles
        apply_reset();
        thread1_fork = 1'b1;
        step();
        clear_inputs();
        rob0_commit = 2'b11; rob0_br_slot = 2'b11; rob0_br_ok_slot = 2'b11;
        rob1_commit = 2'b11; rob1_br_slot = 2'b11; rob1_br_ok_slot = 2'b01;
        repeat (3) step();
        clear_inputs();
        check("g_instr", instr_count, 12);
`ifdef RETIRE_BRANCH_CNT_EN
        check("g_branch", branch_count, 12);
        check("g_correct", correct_branch_count, 9);
`else
        check("g_branch", branch_count, 0);
        check("g_correct", correct_branch_count, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
